// File: rtl/tdm_demux.sv
// Time-division demultiplexer: locks onto the frame marker, collects N serial
// words into a shadow buffer and publishes each complete frame on Q with a strobe.
module tdm_demux #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [W-1:0]   DIN,
  input  logic           VLD,
  input  logic           SOF,
  output logic [N*W-1:0] Q,
  output logic           QVLD,
  output logic [CW-1:0]  CH,
  output logic           LOCK,
  output logic           ERR
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [CW-1:0] IDX_ZERO = CW'(0);
  localparam logic [CW-1:0] IDX_ONE  = CW'(1);
  localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);

  state_e                   state_q, state_d;
  logic [CW-1:0]            idx_q, idx_d;
  logic [N-2:0][W-1:0]      shadow_q, shadow_d;
  logic [N*W-1:0]           q_q, q_d;
  logic                     qvld_q, qvld_d;
  logic                     err_q, err_d;
  logic                     lock_q, lock_d;

  // Next-state, shadow capture and frame publication.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    qvld_d   = 1'b0;
    err_d    = err_q;

    if (VLD) begin
      case (state_q)
        HUNT: begin
          if (SOF) begin
            shadow_d[0] = DIN;
            idx_d       = IDX_ONE;
            state_d     = RUN;
          end else begin
            state_d = HUNT;
          end
        end
        RUN: begin
          if (SOF) begin
            // A marker anywhere but slot 0 abandons the partial frame.
            if (idx_q != IDX_ZERO) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
            shadow_d[0] = DIN;
            idx_d       = IDX_ONE;
          end else if (idx_q == IDX_ZERO) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (idx_q == IDX_LAST) begin
            q_d    = {DIN, shadow_q};
            qvld_d = 1'b1;
            idx_d  = IDX_ZERO;
          end else begin
            shadow_d[idx_q] = DIN;
            idx_d           = idx_q + IDX_ONE;
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = IDX_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    lock_d = (state_d == RUN);
  end

  // State register with synchronous reset taking priority over all inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= HUNT;
      idx_q    <= IDX_ZERO;
      shadow_q <= '0;
      q_q      <= '0;
      qvld_q   <= 1'b0;
      err_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
      qvld_q   <= qvld_d;
      err_q    <= err_d;
      lock_q   <= lock_d;
    end
  end

  assign Q    = q_q;
  assign QVLD = qvld_q;
  assign CH   = idx_q;
  assign LOCK = lock_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux (N=4, W=8): expected frames are queued as the
// last word is driven and popped whenever QVLD is observed.
module tb_tdm_demux;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic           CLK = 1'b0;
  logic           RST;
  logic [W-1:0]   DIN;
  logic           VLD;
  logic           SOF;
  logic [N*W-1:0] Q;
  logic           QVLD;
  logic [CW-1:0]  CH;
  logic           LOCK;
  logic           ERR;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_pulse_cyc = -1;
  int prev_pulse_cyc = -1;
  logic [N*W-1:0] sb[$];

  tdm_demux #(.N(N), .W(W), .CW(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .DIN (DIN),
    .VLD (VLD),
    .SOF (SOF),
    .Q   (Q),
    .QVLD(QVLD),
    .CH  (CH),
    .LOCK(LOCK),
    .ERR (ERR)
  );

  always #5 CLK = ~CLK;

  // Advance one clock, sample 1 time unit after the edge, service the scoreboard.
  task automatic tick();
    logic [N*W-1:0] exp_q;
    @(posedge CLK);
    #1;
    cyc++;
    if (QVLD === 1'b1) begin
      prev_pulse_cyc = last_pulse_cyc;
      last_pulse_cyc = cyc;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_qvld: QVLD=1 at cycle %0d, required no pulse", cyc);
      end else begin
        exp_q = sb.pop_front();
        if (Q !== exp_q) begin
          n_fail++;
          $display("FAIL frame_data: Q=%h required %h", Q, exp_q);
        end
      end
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic s);
    DIN = d; VLD = 1'b1; SOF = s;
    tick();
    VLD = 1'b0; SOF = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives the last word of a frame and requires the strobe right after that edge.
  task automatic send_last(input logic [W-1:0] d, input logic [N*W-1:0] exp_q);
    sb.push_back(exp_q);
    send(d, 1'b0);
    n_cmp++;
    if (QVLD !== 1'b1) begin
      n_fail++;
      $display("FAIL qvld_latency: QVLD=%b required 1", QVLD);
    end
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d frames never strobed, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_status(input string name, input logic e_lock,
                              input logic e_err, input logic [CW-1:0] e_ch);
    n_cmp++;
    if (LOCK !== e_lock || ERR !== e_err || CH !== e_ch) begin
      n_fail++;
      $display("FAIL %s_status: LOCK=%b ERR=%b CH=%0d required LOCK=%b ERR=%b CH=%0d",
               name, LOCK, ERR, CH, e_lock, e_err, e_ch);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; VLD = 1'b0; SOF = 1'b0; DIN = '0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (Q !== 32'h0000_0000 || QVLD !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_q: Q=%h QVLD=%b required 0/0", Q, QVLD);
    end
    check_status("reset", 1'b0, 1'b0, 2'd0);
  endtask

  task automatic test_basic_frame();
    do_reset();
    send(8'h11, 1'b1);
    check_status("basic_ch1", 1'b1, 1'b0, 2'd1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    check_status("basic_ch3", 1'b1, 1'b0, 2'd3);
    send_last(8'h44, 32'h4433_2211);
    check_status("basic_done", 1'b1, 1'b0, 2'd0);
    idle(1);
    n_cmp++;
    if (QVLD !== 1'b0 || Q !== 32'h4433_2211) begin
      n_fail++;
      $display("FAIL basic_pulse_width: QVLD=%b Q=%h required 0/44332211", QVLD, Q);
    end
    check_drained("basic");
  endtask

  task automatic test_gaps();
    logic [W-1:0] w1[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [W-1:0] w2[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(w1[i], (i == 0) ? 1'b1 : 1'b0);
      idle(i);
    end
    idle(3);
    send_last(w1[3], 32'h4433_2211);
    for (int i = 0; i < 3; i++) begin
      idle(3 - i);
      send(w2[i], (i == 0) ? 1'b1 : 1'b0);
      n_cmp++;
      if (Q !== 32'h4433_2211) begin
        n_fail++;
        $display("FAIL gaps_hold: Q=%h required 44332211", Q);
      end
    end
    idle(2);
    send_last(w2[3], 32'hDDCC_BBAA);
    check_status("gaps", 1'b1, 1'b0, 2'd0);
    check_drained("gaps");
  endtask

  task automatic test_hunt_discard();
    do_reset();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    check_status("hunt", 1'b0, 1'b0, 2'd0);
    send(8'hA1, 1'b1);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    send_last(8'hA4, 32'hA4A3_A2A1);
    check_status("hunt_lock", 1'b1, 1'b0, 2'd0);
    check_drained("hunt");
  endtask

  task automatic test_early_sof();
    do_reset();
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h55, 1'b1);
    check_status("early_sof", 1'b1, 1'b1, 2'd1);
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    send_last(8'h88, 32'h8877_6655);
    idle(2);
    check_status("early_sticky", 1'b1, 1'b1, 2'd0);
    check_drained("early");
  endtask

  task automatic test_missing_sof();
    do_reset();
    send(8'h10, 1'b1);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send_last(8'h40, 32'h4030_2010);
    send(8'h99, 1'b0);
    check_status("missing_sof", 1'b0, 1'b1, 2'd0);
    n_cmp++;
    if (Q !== 32'h4030_2010 || QVLD !== 1'b0) begin
      n_fail++;
      $display("FAIL missing_sof_q: Q=%h QVLD=%b required 40302010/0", Q, QVLD);
    end
    check_drained("missing");
  endtask

  task automatic test_rst_midframe();
    do_reset();
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send_last(8'h04, 32'h0403_0201);
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    do_reset();
    n_cmp++;
    if (Q !== 32'h0000_0000 || QVLD !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_q: Q=%h QVLD=%b required 0/0", Q, QVLD);
    end
    check_status("rst_mid", 1'b0, 1'b0, 2'd0);
    send(8'hE1, 1'b1);
    send(8'hE2, 1'b0);
    send(8'hE3, 1'b0);
    send_last(8'hE4, 32'hE4E3_E2E1);
    check_drained("rst_mid");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < N; c++) begin
        d = 8'(f * 16 + c + 1);
        if (c == N - 1) begin
          send_last(d, {d, d - 8'd1, d - 8'd2, d - 8'd3});
        end else begin
          send(d, (c == 0) ? 1'b1 : 1'b0);
        end
      end
    end
    n_cmp++;
    if (last_pulse_cyc - prev_pulse_cyc != N) begin
      n_fail++;
      $display("FAIL b2b_spacing: %0d cycles between pulses, required %0d",
               last_pulse_cyc - prev_pulse_cyc, N);
    end
    check_status("b2b", 1'b1, 1'b0, 2'd0);
    check_drained("b2b");
  endtask

  initial begin
    RST = 1'b1; VLD = 1'b0; SOF = 1'b0; DIN = '0;
    test_reset();
    test_basic_frame();
    test_gaps();
    test_hunt_discard();
    test_early_sof();
    test_missing_sof();
    test_rst_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
